ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the
//  keyboard over the shared open-drain PS2C/PS2D lines. Sits beside the keyboard receiver on the same pins.
//  Drives lines only through active-high pull-low enables; busy tells the receiver to ignore the bus.
// PARAMETERS
//  INHIBIT_CYCLES  12000      clk cycles PS2C held low before request (120 us @ 100 MHz)
//  TIMEOUT_CYCLES  2000000    max clk cycles from clock release to ACK edge (20 ms @ 100 MHz)
//  FILTER_LEN      8          input glitch-filter depth in clk samples
// PORTS
//  clk       in   1  system clock
//  rst       in   1  synchronous, active-high reset
//  tx_data   in   8  byte to send
//  tx_valid  in   1  request; accepted when tx_valid & tx_ready
//  tx_ready  out  1  high only in IDLE
//  tx_done   out  1  one-cycle pulse: frame ACKed and bus idle
//  tx_err    out  1  one-cycle pulse: NACK or timeout
//  busy      out  1  high in every state except IDLE
//  PS2C      in   1  raw clock line
//  PS2D      in   1  raw data line
//  ps2c_oe   out  1  1 = pull PS2C low, 0 = release
//  ps2d_oe   out  1  1 = pull PS2D low, 0 = release
// BEHAVIOUR
//  - Reset: state IDLE, ps2c_oe=ps2d_oe=0, tx_ready=1, busy=0, tx_done=tx_err=0, counters cleared.
//    Reset mid-frame releases both lines on the next clk edge; no done/err pulse.
//  - Filter: FILTER_LEN-deep shift per line; filtered value changes only when all samples agree.
//    fall = filtered PS2C was 1, now 1->0 (one-cycle strobe). Latency raw->strobe = FILTER_LEN+1 cycles.
//  - Accept: latch frame[9:0] = {1'b1 stop, ~^tx_data odd parity, tx_data}; bitcnt=0; -> INHIBIT.
//  - INHIBIT: ps2c_oe=1, ps2d_oe=0 for INHIBIT_CYCLES-1 cycles, then ps2d_oe=1 (start bit) for final cycle.
//  - REQ/SEND: ps2c_oe=0, ps2d_oe held; timeout counter starts at 0.
//    On each fall with bitcnt<10: ps2d_oe <= ~frame[0]; frame >>= 1; bitcnt++.
//    Bits driven: data LSB first (edges 1-8), parity (9), stop = released (10).
//  - ACK: on fall with bitcnt==10 sample filtered PS2D: 0 -> WAIT_IDLE; 1 -> tx_err pulse, IDLE.
//  - WAIT_IDLE: wait until filtered PS2C and PS2D both 1, then tx_done pulse, -> IDLE.
//  - Timeout: counter runs from SEND entry through WAIT_IDLE; reaching TIMEOUT_CYCLES -> release both
//    lines, tx_err pulse, IDLE. Timeout and ACK-fall in the same cycle: ACK result wins.
//  - tx_valid while busy is ignored (not queued). tx_data sampled only at acceptance.
//  - Parity arithmetic: count of ones in {data,parity} is always odd.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined: on NACK or timeout, frame reloaded from latched byte and re-sent via
//    INHIBIT, up to 2 retries; tx_err pulses only after the 3rd failure; busy stays high throughout.
//  Not defined: first NACK/timeout gives tx_err immediately, no retry logic or retry counter built.
// TESTING (INHIBIT_CYCLES=16, TIMEOUT_CYCLES=4000, FILTER_LEN=8, device model clocks at 200-cycle period)
//  - Send 0xED -> PS2C low 16 cycles; device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
//    model ACKs 0 -> single tx_done pulse, lines released, tx_ready=1.
//  - Send 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0; tx_done pulse; no tx_err.
//  - Model answers ACK bit 1 -> tx_err pulse on ACK edge, no tx_done (without PS2_TX_RETRY_EN).
//  - Model never clocks -> tx_err exactly 4000 cycles after PS2C release; ps2c_oe=ps2d_oe=0.
//  - Assert tx_valid with 0x55 during a 0xED frame -> ignored; only 0xED observed on the bus.
//  - rst asserted after 4th data bit -> next cycle ps2c_oe=ps2d_oe=0, IDLE, no pulses;
//    with PS2_TX_RETRY_EN, two NACKs then ACK -> three frames on bus, one tx_done, no tx_err.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10-bit frame shifted on device clock falls, ACK check.
// Optional PS2_TX_RETRY_EN: re-send the latched byte up to twice on NACK/timeout before reporting tx_err.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic       ps2c_oe,
    output logic       ps2d_oe
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_INHIBIT, S_SEND, S_WAIT_IDLE} state_t;

    state_t           state_q, state_d;
    logic [9:0]       frame_q, frame_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_oe_q, c_oe_d;
    logic             d_oe_q, d_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             fail;
`ifdef PS2_TX_RETRY_EN
    logic [7:0]       byte_q, byte_d;
    logic [1:0]       retry_q, retry_d;
`endif

    logic [FILTER_LEN-1:0] c_sh_q, d_sh_q;
    logic                  c_filt_q, d_filt_q, fall_q;

    function automatic logic [9:0] build_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    // Glitch filter: a filtered level only moves once every sample in the window agrees
    always_ff @(posedge clk) begin
        if (rst) begin
            c_sh_q   <= '1;
            d_sh_q   <= '1;
            c_filt_q <= 1'b1;
            d_filt_q <= 1'b1;
            fall_q   <= 1'b0;
        end else begin
            c_sh_q <= {c_sh_q[FILTER_LEN-2:0], PS2C};
            d_sh_q <= {d_sh_q[FILTER_LEN-2:0], PS2D};
            if (&c_sh_q)
                c_filt_q <= 1'b1;
            else if (~|c_sh_q)
                c_filt_q <= 1'b0;
            if (&d_sh_q)
                d_filt_q <= 1'b1;
            else if (~|d_sh_q)
                d_filt_q <= 1'b0;
            fall_q <= c_filt_q & ~|c_sh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            c_oe_q   <= 1'b0;
            d_oe_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
            c_oe_q   <= c_oe_d;
            d_oe_q   <= d_oe_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef PS2_TX_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
`ifdef PS2_TX_RETRY_EN
        byte_q  <= byte_d;
`endif
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        c_oe_d   = c_oe_q;
        d_oe_d   = d_oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fail     = 1'b0;
`ifdef PS2_TX_RETRY_EN
        byte_d   = byte_q;
        retry_d  = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                if (tx_valid) begin
                    frame_d  = build_frame(tx_data);
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    c_oe_d   = 1'b1;
                    state_d  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    byte_d   = tx_data;
                    retry_d  = '0;
`endif
                end
            end
            S_INHIBIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == INH_START)
                    d_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    c_oe_d  = 1'b0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                cnt_d = cnt_q + 1'b1;
                // A fall beats a coincident timeout, so the ACK result wins
                if (fall_q) begin
                    if (bitcnt_q != 4'd10) begin
                        d_oe_d   = ~frame_q[0];
                        frame_d  = {1'b0, frame_q[9:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (!d_filt_q) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = cnt_q + 1'b1;
                if (c_filt_q && d_filt_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    fail = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            c_oe_d = 1'b0;
            d_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d  = retry_q + 2'd1;
                frame_d  = build_frame(byte_q);
                bitcnt_d = '0;
                cnt_d    = '0;
                c_oe_d   = 1'b1;
                state_d  = S_INHIBIT;
            end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
`else
            err_d   = 1'b1;
            state_d = S_IDLE;
`endif
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign tx_done  = done_q;
    assign tx_err   = err_q;
    assign ps2c_oe  = c_oe_q;
    assign ps2d_oe  = d_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural keyboard that clocks frames at a 200-cycle period.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_err, busy;
    logic       PS2C, PS2D;
    logic       ps2c_oe, ps2d_oe;
    logic       dev_c_low, dev_d_low;

    int n_chk  = 0;
    int n_pass = 0;
    int done_tot = 0;
    int err_tot  = 0;
    int inh_tot  = 0;

    assign PS2C = ~(ps2c_oe | dev_c_low);
    assign PS2D = ~(ps2d_oe | dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(16),
        .TIMEOUT_CYCLES(4000),
        .FILTER_LEN(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_done (tx_done),
        .tx_err  (tx_err),
        .busy    (busy),
        .PS2C    (PS2C),
        .PS2D    (PS2D),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_tot <= done_tot + 1;
        if (tx_err)  err_tot  <= err_tot + 1;
        if (ps2c_oe) inh_tot  <= inh_tot + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation ran past 60000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Keyboard model: samples the data line mid-high before each fall, ACKs on the 11th fall if asked
    task automatic dev_frame(input bit ack, input int nfalls, input bit skip_req, output logic [10:0] bits);
        int w;
        bits = '0;
        w = 0;
        if (!skip_req)
            while (ps2c_oe !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        while (ps2c_oe !== 1'b0 && w < 200) begin @(negedge clk); w++; end
        check("req_release", 32'(w < 200), 32'd1);
        repeat (20) @(negedge clk);
        for (int k = 0; k < nfalls; k++) begin
            repeat (50) @(negedge clk);
            bits[k] = PS2D;
            if (k == 10 && ack) dev_d_low = 1'b1;
            repeat (50) @(negedge clk);
            dev_c_low = 1'b1;
            repeat (100) @(negedge clk);
            dev_c_low = 1'b0;
        end
        repeat (50) @(negedge clk);
        dev_d_low = 1'b0;
    endtask

    initial begin
        logic [10:0] bits;
        int d0, e0, i0, n;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        dev_c_low = 1'b0; dev_d_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_c_oe",  32'(ps2c_oe),  32'd0);
        check("rst_d_oe",  32'(ps2d_oe),  32'd0);
        check("rst_pulse", 32'({tx_done, tx_err}), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 0xED: data 1,0,1,1,0,1,1,1 LSB first, six ones -> parity 1
        d0 = done_tot; e0 = err_tot; i0 = inh_tot;
        start_tx(8'hED);
        check("ed_busy", 32'(busy), 32'd1);
        dev_frame(1'b1, 11, 1'b0, bits);
        repeat (30) @(negedge clk);
        check("ed_start", 32'(bits[0]),   32'd0);
        check("ed_data",  32'(bits[8:1]), 32'hED);
        check("ed_par",   32'(bits[9]),   32'd1);
        check("ed_stop",  32'(bits[10]),  32'd1);
        check("ed_inh",   32'(inh_tot - i0),  32'd16);
        check("ed_done",  32'(done_tot - d0), 32'd1);
        check("ed_err",   32'(err_tot - e0),  32'd0);
        check("ed_ready", 32'(tx_ready), 32'd1);
        check("ed_oe",    32'({ps2c_oe, ps2d_oe}), 32'd0);

        // 0xF4: data 0,0,1,0,1,1,1,1, five ones -> parity 0
        d0 = done_tot; e0 = err_tot;
        start_tx(8'hF4);
        dev_frame(1'b1, 11, 1'b0, bits);
        repeat (30) @(negedge clk);
        check("f4_start", 32'(bits[0]),   32'd0);
        check("f4_data",  32'(bits[8:1]), 32'hF4);
        check("f4_par",   32'(bits[9]),   32'd0);
        check("f4_stop",  32'(bits[10]),  32'd1);
        check("f4_done",  32'(done_tot - d0), 32'd1);
        check("f4_err",   32'(err_tot - e0),  32'd0);

        // Request of 0x55 while a 0xED frame is on the bus must be dropped, not queued
        d0 = done_tot; i0 = inh_tot;
        start_tx(8'hED);
        fork
            dev_frame(1'b1, 11, 1'b0, bits);
            begin
                repeat (300) @(negedge clk);
                tx_data = 8'h55; tx_valid = 1'b1;
                repeat (5) @(negedge clk);
                tx_valid = 1'b0; tx_data = 8'h00;
            end
        join
        repeat (250) @(negedge clk);
        check("ign_data", 32'(bits[8:1]), 32'hED);
        check("ign_par",  32'(bits[9]),   32'd1);
        check("ign_done", 32'(done_tot - d0), 32'd1);
        check("ign_inh",  32'(inh_tot - i0),  32'd16);
        check("ign_idle", 32'(busy), 32'd0);

`ifndef PS2_TX_RETRY_EN
        // NACK: device leaves data high on the ACK fall
        d0 = done_tot; e0 = err_tot;
        start_tx(8'h12);
        dev_frame(1'b0, 11, 1'b0, bits);
        repeat (30) @(negedge clk);
        check("nack_data", 32'(bits[8:1]), 32'h12);
        check("nack_par",  32'(bits[9]),   32'd1);
        check("nack_err",  32'(err_tot - e0),  32'd1);
        check("nack_done", 32'(done_tot - d0), 32'd0);
        check("nack_ready", 32'(tx_ready), 32'd1);

        // Silent device: error exactly TIMEOUT_CYCLES after the clock line is released
        d0 = done_tot; e0 = err_tot;
        start_tx(8'hA5);
        n = 0;
        while (ps2c_oe !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (n < 5000) begin
            @(negedge clk);
            n++;
            if (tx_err) break;
        end
        check("to_cycles", 32'(n), 32'd4000);
        check("to_oe",     32'({ps2c_oe, ps2d_oe}), 32'd0);
        repeat (5) @(negedge clk);
        check("to_err",    32'(err_tot - e0),  32'd1);
        check("to_done",   32'(done_tot - d0), 32'd0);
        check("to_ready",  32'(tx_ready), 32'd1);
`else
        // Two NACKs then an ACK: three identical frames, one tx_done, no tx_err
        d0 = done_tot; e0 = err_tot; i0 = inh_tot;
        start_tx(8'hF4);
        dev_frame(1'b0, 11, 1'b0, bits);
        check("rty_busy1", 32'(busy), 32'd1);
        check("rty_data1", 32'(bits[8:1]), 32'hF4);
        dev_frame(1'b0, 11, 1'b1, bits);
        check("rty_busy2", 32'(busy), 32'd1);
        check("rty_data2", 32'(bits[8:1]), 32'hF4);
        dev_frame(1'b1, 11, 1'b1, bits);
        repeat (30) @(negedge clk);
        check("rty_data3", 32'(bits[8:1]), 32'hF4);
        check("rty_inh",   32'(inh_tot - i0),  32'd48);
        check("rty_done",  32'(done_tot - d0), 32'd1);
        check("rty_err",   32'(err_tot - e0),  32'd0);
`endif

        // Reset mid-frame: 0x2C leaves bit 4 (a zero) on the data line after the fifth fall
        d0 = done_tot; e0 = err_tot;
        start_tx(8'h2C);
        dev_frame(1'b0, 5, 1'b0, bits);
        check("mid_bits", 32'(bits[4:0]), 32'b11000);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_d_oe", 32'(ps2d_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_oe",    32'({ps2c_oe, ps2d_oe}), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_pulses", 32'((done_tot - d0) + (err_tot - e0)), 32'd0);
        check("mid_idle",   32'(busy), 32'd0);

        // Recovery after reset
        d0 = done_tot;
        start_tx(8'h5A);
        dev_frame(1'b1, 11, 1'b0, bits);
        repeat (30) @(negedge clk);
        check("rec_data", 32'(bits[8:1]), 32'h5A);
        check("rec_par",  32'(bits[9]),   32'd1);
        check("rec_done", 32'(done_tot - d0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
